// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single port of the 512x32 data memory between the core
// load/store unit (port 0, c_*) and the debug/loader port (port 1, d_*).
// One access is in flight at a time: IDLE picks a winner, ISSUE drives a
// one-cycle wr/rd strobe with the grant, WAIT covers the memory read
// latency, and RESP returns the captured read data to the owning port.
//
// Parameters
//   RD_LATENCY    cycles from rd strobe to rd_data valid (1..7)
//   CORE_PRIORITY 0 = round-robin on ties, 1 = port 0 always wins ties
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   c_req/c_we/c_addr/c_wdata  core request
//   d_req/d_we/d_addr/d_wdata  debug request
//   c_gnt/d_gnt                command accepted pulse
//   c_rvalid/d_rvalid          read data valid pulse
//   c_rdata/d_rdata            read data (zero unless rvalid)
//   wr/rd/addr/wr_data         memory command
//   rd_data                    memory read data
//   busy                       FSM not in IDLE
module dmem_arbiter #(
   parameter int RD_LATENCY    = 1,
   parameter int CORE_PRIORITY = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        c_req,
   input  logic        c_we,
   input  logic [8:0]  c_addr,
   input  logic [31:0] c_wdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [8:0]  d_addr,
   input  logic [31:0] d_wdata,
   output logic        c_gnt,
   output logic        d_gnt,
   output logic        c_rvalid,
   output logic        d_rvalid,
   output logic [31:0] c_rdata,
   output logic [31:0] d_rdata,
   output logic        wr,
   output logic        rd,
   output logic [8:0]  addr,
   output logic [31:0] wr_data,
   input  logic [31:0] rd_data,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

   state_t      state_q, state_d;
   logic [8:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        owner_q, owner_d;   // 0 = core, 1 = debug
   logic        last_q, last_d;     // port granted most recently
   logic [2:0]  cnt_q, cnt_d;
   logic [31:0] rbuf_q, rbuf_d;
   logic        win;

   // Winner for the current IDLE cycle; on a tie round-robin favours the
   // port that was not granted last.
   always_comb begin
      if (c_req && d_req) begin
         win = (CORE_PRIORITY != 0) ? 1'b0 : ~last_q;
      end else begin
         win = d_req;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (c_req || d_req) state_d = ISSUE;
         ISSUE:   state_d = we_q ? IDLE : WAIT;
         WAIT:    if (cnt_q == 3'd0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next-state: command capture, latency counter, read buffer
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      rbuf_d  = rbuf_q;
      case (state_q)
         IDLE: begin
            if (c_req || d_req) begin
               owner_d = win;
               last_d  = win;
               we_d    = win ? d_we    : c_we;
               addr_d  = win ? d_addr  : c_addr;
               wdata_d = win ? d_wdata : c_wdata;
            end
         end
         ISSUE: begin
            if (!we_q) cnt_d = CNT_INIT;
         end
         WAIT: begin
            // The last WAIT cycle is the one where memory data is valid.
            if (cnt_q == 3'd0) begin
               rbuf_d = rd_data;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         rbuf_q  <= '0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         rbuf_q  <= rbuf_d;
      end
   end

   // Outputs decoded from registered state only; the memory command bus is
   // forced to zero outside ISSUE so nothing leaks while idle or in reset.
   always_comb begin
      c_gnt    = 1'b0;
      d_gnt    = 1'b0;
      c_rvalid = 1'b0;
      d_rvalid = 1'b0;
      c_rdata  = '0;
      d_rdata  = '0;
      wr       = 1'b0;
      rd       = 1'b0;
      addr     = '0;
      wr_data  = '0;
      busy     = (state_q != IDLE);
      case (state_q)
         ISSUE: begin
            wr      = we_q;
            rd      = ~we_q;
            addr    = addr_q;
            wr_data = wdata_q;
            c_gnt   = ~owner_q;
            d_gnt   = owner_q;
         end
         RESP: begin
            c_rvalid = ~owner_q;
            d_rvalid = owner_q;
            c_rdata  = owner_q ? 32'd0 : rbuf_q;
            d_rdata  = owner_q ? rbuf_q : 32'd0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_req, c_we, d_req, d_we;
   logic [8:0]  c_addr, d_addr;
   logic [31:0] c_wdata, d_wdata;

   logic        u0_cg, u0_dg, u0_cv, u0_dv, u0_wr, u0_rd, u0_busy;
   logic [31:0] u0_cr, u0_dr, u0_wd, rd_data0;
   logic [8:0]  u0_addr;
   logic        u1_cg, u1_dg, u1_cv, u1_dv, u1_wr, u1_rd, u1_busy;
   logic [31:0] u1_cr, u1_dr, u1_wd, rd_data1;
   logic [8:0]  u1_addr;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_arbiter #(.RD_LATENCY(LAT), .CORE_PRIORITY(0)) u0 (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .c_gnt(u0_cg), .d_gnt(u0_dg), .c_rvalid(u0_cv), .d_rvalid(u0_dv),
      .c_rdata(u0_cr), .d_rdata(u0_dr), .wr(u0_wr), .rd(u0_rd),
      .addr(u0_addr), .wr_data(u0_wd), .rd_data(rd_data0), .busy(u0_busy));

   dmem_arbiter #(.RD_LATENCY(LAT), .CORE_PRIORITY(1)) u1 (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .c_gnt(u1_cg), .d_gnt(u1_dg), .c_rvalid(u1_cv), .d_rvalid(u1_dv),
      .c_rdata(u1_cr), .d_rdata(u1_dr), .wr(u1_wr), .rd(u1_rd),
      .addr(u1_addr), .wr_data(u1_wd), .rd_data(rd_data1), .busy(u1_busy));

   // Memory models: written locations hold data, others a fixed pattern of
   // the address; read data is valid exactly LAT cycles after rd.
   logic [31:0] mem0 [512];
   logic [31:0] mem1 [512];
   bit          wv0  [512];
   bit          wv1  [512];
   logic        p0v1 = 1'b0, p0v2 = 1'b0, p1v1 = 1'b0, p1v2 = 1'b0;
   logic [8:0]  p0a1, p0a2, p1a1, p1a2;

   function automatic logic [31:0] mhash(input logic [8:0] a);
      return {7'h35, a, ~a, a[6:0]};
   endfunction

   function automatic logic [31:0] mread(input int inst, input logic [8:0] a);
      if (inst == 0) return wv0[a] ? mem0[a] : mhash(a);
      return wv1[a] ? mem1[a] : mhash(a);
   endfunction

   always @(posedge clk) begin
      if (u0_wr) begin
         mem0[u0_addr] <= u0_wd;
         wv0[u0_addr]  <= 1'b1;
      end
      if (u1_wr) begin
         mem1[u1_addr] <= u1_wd;
         wv1[u1_addr]  <= 1'b1;
      end
      p0v1 <= u0_rd; p0a1 <= u0_addr; p0v2 <= p0v1; p0a2 <= p0a1;
      p1v1 <= u1_rd; p1a1 <= u1_addr; p1v2 <= p1v1; p1a2 <= p1a1;
   end

   assign rd_data0 = p0v2 ? mread(0, p0a2) : 32'hBAD0_BAD0;
   assign rd_data1 = p1v2 ? mread(1, p1a2) : 32'hBAD0_BAD0;

   // Sampled view of one instance
   logic        s_cg, s_dg, s_cv, s_dv, s_wr, s_rd, s_busy;
   logic [31:0] s_cr, s_dr, s_wd;
   logic [8:0]  s_addr;
   logic [111:0] outs;

   task automatic sample(input int inst);
      if (inst == 0) begin
         s_cg = u0_cg; s_dg = u0_dg; s_cv = u0_cv; s_dv = u0_dv;
         s_cr = u0_cr; s_dr = u0_dr; s_wr = u0_wr; s_rd = u0_rd;
         s_addr = u0_addr; s_wd = u0_wd; s_busy = u0_busy;
      end else begin
         s_cg = u1_cg; s_dg = u1_dg; s_cv = u1_cv; s_dv = u1_dv;
         s_cr = u1_cr; s_dr = u1_dr; s_wr = u1_wr; s_rd = u1_rd;
         s_addr = u1_addr; s_wd = u1_wd; s_busy = u1_busy;
      end
      outs = {s_cg, s_dg, s_cv, s_dv, s_cr, s_dr, s_wr, s_rd, s_addr, s_wd, s_busy};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      tick(); tick();
      for (int i = 0; i < 2; i++) begin
         sample(i);
         n_chk++;
         if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outs inst%0d: got %h required 0", i, outs);
         end
      end
      reset = 1'b1;
      tick(); tick();
      sample(0);
      n_chk++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL reset_idle: got %h required 0", outs);
      end
   endtask

   task automatic test_write();
      c_req = 1'b1; c_we = 1'b1; c_addr = 9'd5; c_wdata = 32'hDEADBEEF;
      tick();
      sample(0);
      n_chk++;
      if ({s_wr, s_rd, s_cg, s_dg, s_busy} !== 5'b10101) begin
         n_fail++;
         $display("FAIL wr_issue_ctl: got wr/rd/cg/dg/busy=%b required 10101",
                  {s_wr, s_rd, s_cg, s_dg, s_busy});
      end
      n_chk++;
      if (s_addr !== 9'd5 || s_wd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr_issue_bus: got addr=%0d data=%h required 5 DEADBEEF", s_addr, s_wd);
      end
      c_req = 1'b0;
      tick();
      sample(0);
      n_chk++;
      if ({s_wr, s_cg, s_busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL wr_done: got wr/cg/busy=%b required 000", {s_wr, s_cg, s_busy});
      end
      n_chk++;
      if (mread(0, 9'd5) !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr_mem: got %h required DEADBEEF", mread(0, 9'd5));
      end
   endtask

   task automatic test_read_debug();
      d_req = 1'b1; d_we = 1'b1; d_addr = 9'h20; d_wdata = 32'h12345678;
      tick();
      sample(0);
      n_chk++;
      if ({s_dg, s_cg, s_wr} !== 3'b101) begin
         n_fail++;
         $display("FAIL dwr_issue: got dg/cg/wr=%b required 101", {s_dg, s_cg, s_wr});
      end
      d_req = 1'b0;
      tick();
      d_req = 1'b1; d_we = 1'b0;
      tick();
      sample(0);
      n_chk++;
      if ({s_dg, s_cg, s_rd, s_wr} !== 4'b1010 || s_addr !== 9'h20) begin
         n_fail++;
         $display("FAIL drd_issue: got dg/cg/rd/wr=%b addr=%h required 1010 020",
                  {s_dg, s_cg, s_rd, s_wr}, s_addr);
      end
      d_req = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         tick();
         sample(0);
         n_chk++;
         if (s_dv !== (k == 4) || s_dr !== ((k == 4) ? 32'h12345678 : 32'd0) ||
             s_cv !== 1'b0 || s_busy !== (k <= 4) || s_dg !== 1'b0 || s_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL drd_N+%0d: got dv=%b dr=%h cv=%b busy=%b dg=%b rd=%b required dv=%b dr=%h cv=0 busy=%b dg=0 rd=0",
                     k, s_dv, s_dr, s_cv, s_busy, s_dg, s_rd, (k == 4),
                     (k == 4) ? 32'h12345678 : 32'd0, (k <= 4));
         end
      end
   endtask

   task automatic test_contention(input int inst);
      int          ngr, nresp, gcyc, eport;
      logic        outst, oport;
      logic [31:0] edata;
      ngr = 0; nresp = 0; gcyc = 0; outst = 1'b0; oport = 1'b0; edata = '0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      c_req = 1'b1; c_we = 1'b0; c_addr = 9'($urandom_range(0, 511));
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'($urandom_range(0, 511));
      for (int t = 0; t < 200 && nresp < 8; t++) begin
         tick();
         sample(inst);
         if (s_wr && s_rd) begin
            n_chk++; n_fail++;
            $display("FAIL cont%0d_overlap: wr and rd both high at cycle %0d", inst, cyc);
         end
         if (s_cg || s_dg) begin
            eport = (inst == 1) ? 0 : (ngr % 2);
            n_chk++;
            if ((s_cg && s_dg) || int'(s_dg) != eport) begin
               n_fail++;
               $display("FAIL cont%0d_grant%0d: got cg/dg=%b%b required port %0d",
                        inst, ngr, s_cg, s_dg, eport);
            end
            n_chk++;
            if (s_rd !== 1'b1 || outst) begin
               n_fail++;
               $display("FAIL cont%0d_issue%0d: got rd=%b outstanding=%b required rd=1 outstanding=0",
                        inst, ngr, s_rd, outst);
            end
            n_chk++;
            if (s_addr !== (s_dg ? d_addr : c_addr)) begin
               n_fail++;
               $display("FAIL cont%0d_addr%0d: got %0d required %0d",
                        inst, ngr, s_addr, s_dg ? d_addr : c_addr);
            end
            oport = s_dg;
            edata = mread(inst, s_dg ? d_addr : c_addr);
            gcyc  = cyc;
            outst = 1'b1;
            ngr++;
            if (s_dg) d_addr = 9'($urandom_range(0, 511));
            else      c_addr = 9'($urandom_range(0, 511));
         end
         if (s_cv || s_dv) begin
            n_chk++;
            if (!outst || (s_cv && s_dv) || s_dv !== oport || cyc != gcyc + LAT + 1) begin
               n_fail++;
               $display("FAIL cont%0d_rvalid%0d: got cv/dv=%b%b at +%0d required port %0d at +%0d",
                        inst, nresp, s_cv, s_dv, cyc - gcyc, oport, LAT + 1);
            end
            n_chk++;
            if ((oport ? s_dr : s_cr) !== edata || (oport ? s_cr : s_dr) !== 32'd0) begin
               n_fail++;
               $display("FAIL cont%0d_rdata%0d: got c=%h d=%h required owner data %h other 0",
                        inst, nresp, s_cr, s_dr, edata);
            end
            outst = 1'b0;
            nresp++;
         end else if (s_cr !== 32'd0 || s_dr !== 32'd0) begin
            n_chk++; n_fail++;
            $display("FAIL cont%0d_rdata_idle: got c=%h d=%h required 0", inst, s_cr, s_dr);
         end
      end
      idle_inputs();
      n_chk++;
      if (nresp != 8) begin
         n_fail++;
         $display("FAIL cont%0d_timeout: got %0d responses required 8", inst, nresp);
      end
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      d_req = 1'b1; d_we = 1'b0; d_addr = 9'h33;
      tick();
      sample(0);
      n_chk++;
      if (s_dg !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_gnt: got dg=%b required 1", s_dg);
      end
      d_req = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      sample(0);
      n_chk++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL rmid_async: got %h required 0", outs);
      end
      tick(); tick();
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         sample(0);
         n_chk++;
         if (outs !== '0) begin
            n_fail++;
            $display("FAIL rmid_quiet%0d: got %h required 0", k, outs);
         end
      end
      c_req = 1'b1; c_we = 1'b1; c_addr = 9'd7; c_wdata = 32'hCAFE0007;
      tick();
      sample(0);
      n_chk++;
      if ({s_cg, s_wr} !== 2'b11 || s_addr !== 9'd7) begin
         n_fail++;
         $display("FAIL rmid_next: got cg/wr=%b addr=%0d required 11 7", {s_cg, s_wr}, s_addr);
      end
      c_req = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      int          rcyc;
      bit          seen;
      w = $urandom;
      seen = 1'b0;
      c_req = 1'b1; c_we = 1'b1; c_addr = 9'd511; c_wdata = w;
      tick();
      sample(0);
      n_chk++;
      if ({s_wr, s_rd, s_cg} !== 3'b101 || s_addr !== 9'd511 || s_wd !== w) begin
         n_fail++;
         $display("FAIL b2b_wr: got wr/rd/cg=%b addr=%0d data=%h required 101 511 %h",
                  {s_wr, s_rd, s_cg}, s_addr, s_wd, w);
      end
      c_we = 1'b0;
      tick();
      sample(0);
      n_chk++;
      if ({s_wr, s_rd, s_cg, s_busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL b2b_gap: got wr/rd/cg/busy=%b required 0000", {s_wr, s_rd, s_cg, s_busy});
      end
      tick();
      sample(0);
      rcyc = cyc;
      n_chk++;
      if ({s_wr, s_rd, s_cg} !== 3'b011 || s_addr !== 9'd511) begin
         n_fail++;
         $display("FAIL b2b_rd: got wr/rd/cg=%b addr=%0d required 011 511",
                  {s_wr, s_rd, s_cg}, s_addr);
      end
      c_req = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         tick();
         sample(0);
         if (s_wr && s_rd) begin
            n_chk++; n_fail++;
            $display("FAIL b2b_overlap: wr and rd both high at cycle %0d", cyc);
         end
         if (s_cv) begin
            seen = 1'b1;
            n_chk++;
            if (s_cr !== w || cyc != rcyc + LAT + 1) begin
               n_fail++;
               $display("FAIL b2b_rdata: got %h at +%0d required %h at +%0d",
                        s_cr, cyc - rcyc, w, LAT + 1);
            end
         end
      end
      n_chk++;
      if (!seen) begin
         n_fail++;
         $display("FAIL b2b_timeout: got no c_rvalid required one");
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_debug();
      test_contention(0);
      test_contention(1);
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the 512-word x 32-bit data memory of the RISC-V core. It shares the single memory port between the core load/store unit (port 0) and a debug/loader port (port 1). It issues one-cycle `wr`/`rd` strobes, waits out the memory read latency, and returns read data to the owning requester. It sits between the core datapath and the data memory. Its memory-side outputs are the `wr`, `rd`, `addr`, `wr_data`, `rd_data` signals the top-level bench monitors.

## Interface
- `RD_LATENCY`, default 1: cycles from the `rd` strobe to `rd_data` being valid; legal range 1..7.
- `CORE_PRIORITY`, default 0: selects the arbitration policy.
  - 0: round-robin.
  - 1: port 0 always wins ties.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `c_req`, `d_req` in 1: access request (core, debug).
- `c_we`, `d_we` in 1: 1 = write, 0 = read.
- `c_addr`, `d_addr` in 9: word address.
- `c_wdata`, `d_wdata` in 32: write data.
- `c_gnt`, `d_gnt` out 1: one-cycle pulse; the command has been accepted.
- `c_rvalid`, `d_rvalid` out 1: one-cycle pulse; read data is valid.
- `c_rdata`, `d_rdata` out 32: read data, meaningful only while the matching rvalid is high.
- `wr`, `rd` out 1: memory write/read strobes.
- `addr` out 9: memory address.
- `wr_data` out 32: memory write data.
- `rd_data` in 32: memory read data.
- `busy` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high at a clock edge, the arbiter picks a winner and goes to ISSUE. On that edge it registers the winner's `addr`, `wr_data` and `we`, and sets `owner`. Otherwise it stays in IDLE.
- ISSUE, one cycle:
  - `wr` = we and `rd` = !we; exactly one of them is high.
  - The winner's gnt is high.
  - Next state: IDLE for a write; WAIT for a read, with `cnt` loaded to RD_LATENCY-1.
- WAIT: lasts RD_LATENCY cycles. `wr`, `rd` and gnt are low. `cnt` decrements each cycle. On the edge ending the last WAIT cycle, `rd_data` is captured into `rbuf` and the FSM goes to RESP.
- RESP, one cycle: the owner's rvalid is high and its rdata = `rbuf`. Next state: IDLE.
- Arbitration applies only in IDLE:
  - Only one req high: that port wins.
  - Both high, CORE_PRIORITY=0: the port not granted last wins.
  - Both high, CORE_PRIORITY=1: port 0 wins.
  - `last` register updates on every grant; reset value = port 1, so port 0 wins the first tie.
- Requester rules: hold req, we, addr and wdata stable until gnt. Drop req in the cycle after gnt unless issuing another access. A req that is still high in IDLE is treated as a new request.
- The arbiter never issues a new command while a read is outstanding. There is one access in flight at most.
- `wr` and `rd` are never high together. The non-owner's gnt, rvalid and rdata are always 0.
- Reset values, in all states: every output is 0, state = IDLE, `cnt` = 0, `rbuf` = 0, `last` = 1.
- Reset asserted mid-operation: the in-flight access is abandoned. No strobe, gnt or rvalid appears after reset is released until a new req is sampled.

## Timing
- Reference point: req is sampled at edge E (the end of cycle N).
- ISSUE, with gnt, `wr`/`rd` and `addr` valid, occurs in cycle N+1.
- Write: the memory writes at the end of cycle N+1. The FSM is back in IDLE in cycle N+2. Sustained throughput is one write per 2 cycles.
- Read: WAIT spans cycles N+2..N+1+RD_LATENCY. rvalid is in cycle N+2+RD_LATENCY. The FSM is back in IDLE in cycle N+3+RD_LATENCY.
- All outputs are registered or decoded from registered state only. There are no combinational paths from req inputs to outputs.
- The losing requester is served starting from the IDLE cycle that follows the current transaction.

## Test plan
- Port 0 write: c_req=1, c_we=1, c_addr=9'd5, c_wdata=32'hDEADBEEF sampled at edge E.
  - Required: wr=1, addr=5, wr_data=DEADBEEF and c_gnt=1 for exactly cycle N+1.
  - busy falls in cycle N+2.
- Port 1 read with RD_LATENCY=2: the memory model returns 32'h12345678 two cycles after rd.
  - Required: d_gnt in N+1 and d_rvalid=1 with d_rdata=12345678 in N+4 only.
  - c_rvalid stays 0 throughout.
- Both ports hold req continuously with reads, CORE_PRIORITY=0.
  - Required: grants alternate 0,1,0,1.
  - Each rvalid goes only to its owner, and rd never overlaps an outstanding read.
- Same stimulus with CORE_PRIORITY=1.
  - Required: port 0 is granted every transaction; d_gnt never asserts while c_req is high.
- Reset pulsed low during WAIT of a read.
  - Required: all outputs are 0 immediately, with no d_rvalid/c_rvalid afterwards.
  - The next request after release sees the normal N+1 gnt timing.
- Back-to-back port 0 write then read to addr 9'd511.
  - Required: wr in N+1, then rd in N+3 with addr=511.
  - wr and rd are never high in the same cycle.
